// File: rtl/ipml_sync_prefetch_fifo_v2_0_pkg.sv
// Shared constants and helpers for the prefetch FIFO.
// Parity helper is only referenced under IPML_PREFETCH_FIFO_PARITY_EN.
package ipml_prefetch_fifo_pkg;

  localparam int PF_DEPTH = 2;
  localparam int MAX_DW   = 1152;

  function automatic int lvl_w(input int dw);
    return dw + 1;
  endfunction

  function automatic logic even_par(
    input logic [MAX_DW-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/ipml_sync_prefetch_fifo_v2_0_if.sv
// Write/read handshake, status and flush bundle of the prefetch FIFO.
// master = producer/consumer side, slave = FIFO side.
interface ipml_sync_prefetch_fifo_v2_0_if #(
  parameter int DW = 32,
  parameter int LW = 11
);

  logic          clr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_vld;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          rd_vld;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic          wr_ovf;
  logic          rd_udf;
  logic          rd_par_err;

  modport master (
    output clr, wr_data, wr_en, rd_en,
    input  wr_vld, rd_data, rd_vld, level,
    input  almost_full, almost_empty,
    input  wr_ovf, rd_udf, rd_par_err
  );

  modport slave (
    input  clr, wr_data, wr_en, rd_en,
    output wr_vld, rd_data, rd_vld, level,
    output almost_full, almost_empty,
    output wr_ovf, rd_udf, rd_par_err
  );

endinterface

// File: rtl/ipml_sync_prefetch_fifo_v2_0_out_buf.sv
// Two-entry registered skid buffer feeding the FIFO head.
// Head word is zeroed when the buffer drains.
module ipml_prefetch_out_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [1:0]   cnt
);

  logic         t_vld;
  logic [W-1:0] t_dat;
  logic         pop;
  logic         acc;

  assign pop    = out_vld & out_rdy;
  assign in_rdy = ~t_vld | pop;
  assign acc    = in_vld & in_rdy;
  assign cnt    = {t_vld, out_vld & ~t_vld};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      t_vld    <= 1'b0;
      t_dat    <= '0;
    end else if (clr) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      t_vld    <= 1'b0;
      t_dat    <= '0;
    end else if (pop) begin
      if (t_vld) begin
        out_data <= t_dat;
        t_vld    <= acc;
        if (acc) t_dat <= in_data;
      end else if (acc) begin
        out_data <= in_data;
      end else begin
        out_vld  <= 1'b0;
        out_data <= '0;
      end
    end else if (acc) begin
      if (!out_vld) begin
        out_vld  <= 1'b1;
        out_data <= in_data;
      end else begin
        t_vld <= 1'b1;
        t_dat <= in_data;
      end
    end
  end

endmodule

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// FWFT FIFO: SDP RAM + 2-entry prefetch buffer, level and flags.
// Optional head-word parity: define IPML_PREFETCH_FIFO_PARITY_EN.
module ipml_sync_prefetch_fifo_v2_0
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int c_DEPTH_WIDTH = 10,
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_AF_LEVEL    = (1 << c_DEPTH_WIDTH) - 4,
  parameter int c_AE_LEVEL    = 4
) (
  input logic clk,
  input logic rst,
  ipml_sync_prefetch_fifo_v2_0_if.slave bus
);

  localparam int N  = 1 << c_DEPTH_WIDTH;
  localparam int LW = lvl_w(c_DEPTH_WIDTH);
  localparam int DW = c_DATA_WIDTH;

  localparam logic [LW-1:0] FULL_L = LW'(N);
  localparam logic [LW-1:0] AF_L   = LW'(c_AF_LEVEL);
  localparam logic [LW-1:0] AE_L   = LW'(c_AE_LEVEL);

`ifdef IPML_PREFETCH_FIFO_PARITY_EN
  localparam int RW = DW + 1;
`else
  localparam int RW = DW;
`endif

  logic [RW-1:0]            ram [N];
  logic [RW-1:0]            ram_q;
  logic [RW-1:0]            ram_wd;
  logic [RW-1:0]            buf_in;
  logic [RW-1:0]            head;
  logic [c_DEPTH_WIDTH-1:0] wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]            ram_cnt;
  logic [LW-1:0]            lvl_nxt;
  logic                     rd_pend;
  logic                     rd_iss;
  logic                     wr_acc;
  logic                     pop;
  logic [1:0]               buf_cnt;
  logic [1:0]               occ;
  logic                     buf_rdy;

  assign wr_acc = bus.wr_en & bus.wr_vld & ~bus.clr;
  assign pop    = bus.rd_en & bus.rd_vld & ~bus.clr;

  // Buffer slots committed after this edge, counting the read in flight.
  assign occ    = buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
  assign rd_iss = (ram_cnt != '0) & (occ < 2'(PF_DEPTH)) & ~bus.clr;

  always_comb begin
    lvl_nxt = bus.level + LW'(wr_acc) - LW'(pop);
  end

`ifdef IPML_PREFETCH_FIFO_PARITY_EN
  logic [MAX_DW-1:0] wd_ext;
  logic [MAX_DW-1:0] rq_ext;
  logic              q_err;

  always_comb begin
    wd_ext         = '0;
    wd_ext[DW-1:0] = bus.wr_data;
    rq_ext         = '0;
    rq_ext[DW-1:0] = ram_q[DW-1:0];
  end

  assign ram_wd         = {even_par(wd_ext), bus.wr_data};
  assign q_err          = even_par(rq_ext) ^ ram_q[DW];
  assign buf_in         = {q_err, ram_q[DW-1:0]};
  assign bus.rd_par_err = head[DW];
`else
  assign ram_wd         = bus.wr_data;
  assign buf_in         = ram_q;
  assign bus.rd_par_err = 1'b0;
`endif

  assign bus.rd_data = head[DW-1:0];

  always_ff @(posedge clk) begin
    if (wr_acc) ram[wr_ptr] <= ram_wd;
  end

  always_ff @(posedge clk) begin
    if (rd_iss) ram_q <= ram[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ram_cnt          <= '0;
      rd_pend          <= 1'b0;
      bus.level        <= '0;
      bus.wr_vld       <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.wr_ovf       <= 1'b0;
      bus.rd_udf       <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ram_cnt          <= '0;
      rd_pend          <= 1'b0;
      bus.level        <= '0;
      bus.wr_vld       <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.wr_ovf       <= 1'b0;
      bus.rd_udf       <= 1'b0;
    end else begin
      wr_ptr           <= wr_ptr + c_DEPTH_WIDTH'(wr_acc);
      rd_ptr           <= rd_ptr + c_DEPTH_WIDTH'(rd_iss);
      ram_cnt          <= ram_cnt + LW'(wr_acc) - LW'(rd_iss);
      rd_pend          <= rd_iss;
      bus.level        <= lvl_nxt;
      bus.wr_vld       <= lvl_nxt != FULL_L;
      bus.almost_full  <= lvl_nxt >= AF_L;
      bus.almost_empty <= lvl_nxt <= AE_L;
      bus.wr_ovf       <= bus.wr_ovf | (bus.wr_en & ~bus.wr_vld);
      bus.rd_udf       <= bus.rd_udf | (bus.rd_en & ~bus.rd_vld);
    end
  end

  ipml_prefetch_out_buf #(
    .W (RW)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .in_vld   (rd_pend & buf_rdy),
    .in_data  (buf_in),
    .in_rdy   (buf_rdy),
    .out_data (head),
    .out_vld  (bus.rd_vld),
    .out_rdy  (bus.rd_en),
    .cnt      (buf_cnt)
  );

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// Directed bench for the prefetch FIFO (depth 2**10, 32-bit words).
// Parity-flip case builds only with IPML_PREFETCH_FIFO_PARITY_EN.
module tb_ipml_sync_prefetch_fifo_v2_0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_run  = 0;
  int n_fail = 0;
  int bad;

  ipml_sync_prefetch_fifo_v2_0_if #(.DW(32), .LW(11)) bus ();

  ipml_sync_prefetch_fifo_v2_0 #(
    .c_DEPTH_WIDTH (10),
    .c_DATA_WIDTH  (32),
    .c_AF_LEVEL    (1020),
    .c_AE_LEVEL    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.clr   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    idle();
    bus.wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wr_vld", bus.wr_vld, 1);
    chk("rst_rd_vld", bus.rd_vld, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_ovf", bus.wr_ovf, 0);
    chk("rst_udf", bus.rd_udf, 0);
    chk("rst_par", bus.rd_par_err, 0);
    chk("rst_data", bus.rd_data, 0);

    // single word latency
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hA5A5_0001;
    tick();
    bus.wr_en = 1'b0;
    chk("t1_e0_vld", bus.rd_vld, 0);
    chk("t1_e0_lvl", bus.level, 1);
    tick();
    chk("t1_e1_vld", bus.rd_vld, 0);
    tick();
    chk("t1_e2_vld", bus.rd_vld, 1);
    chk("t1_data", bus.rd_data, 32'hA5A5_0001);
    chk("t1_level", bus.level, 1);
    chk("t1_ae", bus.almost_empty, 1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t1_pop_lvl", bus.level, 0);
    chk("t1_pop_vld", bus.rd_vld, 0);

    // fill to full
    for (int i = 0; i < 1024; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 32'(i);
      tick();
      if (i == 1018) chk("t2_af_1019", bus.almost_full, 0);
      if (i == 1019) chk("t2_af_1020", bus.almost_full, 1);
      if (i == 4) chk("t2_ae_5", bus.almost_empty, 0);
    end
    chk("t2_level", bus.level, 1024);
    chk("t2_wr_vld", bus.wr_vld, 0);
    chk("t2_af", bus.almost_full, 1);
    chk("t2_head", bus.rd_data, 0);
    bus.wr_data = 32'hDEAD;
    tick();
    chk("t2_ovf", bus.wr_ovf, 1);
    chk("t2_ovf_lvl", bus.level, 1024);
    chk("t2_ovf_head", bus.rd_data, 0);
    // write with pop while full is refused
    bus.wr_data = 32'hBEEF;
    bus.rd_en   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("t2_wp_lvl", bus.level, 1023);
    chk("t2_wp_wr_vld", bus.wr_vld, 1);
    bad = 0;
    for (int i = 1; i < 1024; i++) begin
      if (!bus.rd_vld || bus.rd_data != 32'(i)) bad++;
      tick();
    end
    bus.rd_en = 1'b0;
    chk("t2_drain", bad, 0);
    chk("t2_end_lvl", bus.level, 0);
    chk("t2_end_vld", bus.rd_vld, 0);
    chk("t2_end_udf", bus.rd_udf, 0);
    chk("t2_ovf_sticky", bus.wr_ovf, 1);

    // underflow on empty
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t4_udf", bus.rd_udf, 1);
    chk("t4_lvl", bus.level, 0);
    chk("t4_vld", bus.rd_vld, 0);

    // flush at level 37 with concurrent write and read
    for (int i = 0; i < 37; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 32'(100 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    tick();
    chk("t5_pre_lvl", bus.level, 37);
    chk("t5_pre_head", bus.rd_data, 100);
    bus.clr   = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    idle();
    chk("t5_lvl", bus.level, 0);
    chk("t5_vld", bus.rd_vld, 0);
    chk("t5_wr_vld", bus.wr_vld, 1);
    chk("t5_ovf", bus.wr_ovf, 0);
    chk("t5_udf", bus.rd_udf, 0);
    chk("t5_ae", bus.almost_empty, 1);
    chk("t5_data", bus.rd_data, 0);
    tick();
    tick();
    chk("t5_post_vld", bus.rd_vld, 0);

    // steady streaming at level 8
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    tick();
    chk("t3_lvl", bus.level, 8);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.wr_data = 32'(8 + k);
      if (!bus.rd_vld || bus.rd_data != 32'(k)) bad++;
      tick();
      if (bus.level != 11'd8) bad++;
    end
    idle();
    chk("t3_stream", bad, 0);
    chk("t3_next", bus.rd_data, 100);
    chk("t3_end_lvl", bus.level, 8);

    // asynchronous reset mid-burst
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'h55;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rb_lvl", bus.level, 0);
    chk("rb_vld", bus.rd_vld, 0);
    chk("rb_wr_vld", bus.wr_vld, 1);
    chk("rb_ae", bus.almost_empty, 1);
    chk("rb_data", bus.rd_data, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("rb_after", bus.level, 0);

`ifdef IPML_PREFETCH_FIFO_PARITY_EN
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 32'(i + 32'h10);
      tick();
    end
    bus.wr_en = 1'b0;
    dut.ram[3][0] = ~dut.ram[3][0];
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("par_err", bus.rd_par_err, (i == 3) ? 1 : 0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      tick();
    end
    chk("par_idle", bus.rd_par_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
